// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the pulse-stretching link transmitter.
// Contents:
//   state_e  - transmitter FSM state (idle, high phase, low phase)
//   MIN_CYC  - smallest legal HIGH_CYC / LOW_CYC
//   max_u    - maximum of two unsigned values, used for timer sizing
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2
  } state_e;

  // Two-flop synchronizer plus edge detector on the far side needs at least 3 cycles per level
  localparam int unsigned MIN_CYC = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   inc      - count up by one (saturates at all-ones)
//   dec      - count down by one (floors at zero)
//   count    - registered count value
//   sat_drop - registered one-cycle flag: an increment was lost at saturation
// inc and dec together cancel and never raise sat_drop.
module sat_updown_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  localparam logic [W-1:0] CntMax = '1;

  logic [W-1:0] count_q, count_d;
  logic         drop_q, drop_d;

  always_comb begin
    count_d = count_q;
    drop_d  = 1'b0;
    if (inc && !dec) begin
      if (count_q != CntMax) begin
        count_d = count_q + 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      drop_q  <= drop_d;
    end
  end

  assign count    = count_q;
  assign sat_drop = drop_q;

endmodule

// File: rtl/pulse_stretch_tx.sv
// Transmit side of the edge-signalling link: turns single-cycle requests into level pulses
// high for HIGH_CYC cycles followed by at least LOW_CYC low cycles. Requests arriving while a
// pulse is in flight are queued in a saturating pending counter.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   pulse_in - request; every high cycle is one request
//   sig_out  - registered level pulse to the remote receiver
//   busy     - pulse in flight or requests pending
//   pending  - queued requests not yet transmitted
//   overflow - registered one-cycle flag: a request was dropped
module pulse_stretch_tx
  import pulse_tx_pkg::*;
#(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned LOW_CYC  = 4,
  parameter int unsigned PEND_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  if (HIGH_CYC < MIN_CYC) begin : g_bad_high
    $error("HIGH_CYC must be at least 3");
  end
  if (LOW_CYC < MIN_CYC) begin : g_bad_low
    $error("LOW_CYC must be at least 3");
  end

  localparam int unsigned TW = $clog2(max_u(HIGH_CYC, LOW_CYC)) + 1;
  localparam logic [TW-1:0] HighLoad = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0] LowLoad  = TW'(LOW_CYC - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            sig_q, sig_d;
  logic            cnt_inc, cnt_dec;
  logic            pend_nz;
  logic [PEND_W-1:0] pend_cnt;

  assign pend_nz = (pend_cnt != '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sig_d   = sig_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      StIdle: begin
        if (pulse_in) begin
          state_d = StHigh;
          sig_d   = 1'b1;
          tmr_d   = HighLoad;
        end
      end
      StHigh: begin
        cnt_inc = pulse_in;
        if (tmr_q == '0) begin
          state_d = StLow;
          sig_d   = 1'b0;
          tmr_d   = LowLoad;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StLow: begin
        if (tmr_q == '0) begin
          if (pend_nz || pulse_in) begin
            state_d = StHigh;
            sig_d   = 1'b1;
            tmr_d   = HighLoad;
            // The restart consumes one request: a queued one if any, else the live one.
            // A live request alongside a queued one replaces it, so the count holds.
            cnt_dec = pend_nz;
            cnt_inc = pulse_in && pend_nz;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tmr_d   = tmr_q - 1'b1;
          cnt_inc = pulse_in;
        end
      end
      default: begin
        state_d = StIdle;
        sig_d   = 1'b0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      sig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sig_q   <= sig_d;
    end
  end

  sat_updown_cnt #(
    .W(PEND_W)
  ) u_pend_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (cnt_inc),
    .dec      (cnt_dec),
    .count    (pend_cnt),
    .sat_drop (overflow)
  );

  assign sig_out = sig_q;
  assign pending = pend_cnt;
  assign busy    = (state_q != StIdle) || pend_nz;

endmodule

// File: tb/tb_pulse_stretch_tx.sv
module tb_pulse_stretch_tx;

  localparam int H      = 4;
  localparam int L      = 4;
  localparam int PW     = 3;
  localparam int MAXP   = (1 << PW) - 1;
  localparam int NSCEN  = 6;
  localparam int SCEN_LEN = 80;
  localparam int RAND_LEN = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pulse_in = 1'b0;
  logic          sig_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  pulse_stretch_tx #(
    .HIGH_CYC(H),
    .LOW_CYC (L),
    .PEND_W  (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse_in(pulse_in),
    .sig_out (sig_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit sig;
    bit busy;
    int pend;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model in terms of pulse start times: a pulse starting in cycle s is high for
  // s..s+H-1 and low for s+H..s+H+L-1; the last low cycle may launch the next pulse.
  bit m_active = 0;
  int m_start  = 0;
  int m_pend   = 0;
  bit m_ovf    = 0;

  task automatic model_step(input bit p, input bit r, input int c);
    exp_t e;
    if (r) begin
      m_active = 0;
      m_pend   = 0;
      m_ovf    = 0;
    end else begin
      m_ovf = 0;
      if (!m_active) begin
        if (p) begin
          m_active = 1;
          m_start  = c + 1;
        end
      end else if (c == m_start + H + L - 1) begin
        if (m_pend > 0 || p) begin
          m_start = c + 1;
          if (m_pend > 0 && !p) m_pend = m_pend - 1;
        end else begin
          m_active = 0;
        end
      end else if (p) begin
        if (m_pend < MAXP) m_pend = m_pend + 1;
        else m_ovf = 1;
      end
    end
    e.cyc  = c + 1;
    e.sig  = m_active && ((c + 1 - m_start) < H);
    e.busy = m_active || (m_pend > 0);
    e.pend = m_pend;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit p, input bit r);
    @(posedge clk);
    #1;
    pulse_in = p;
    rst      = r;
    model_step(p, r, cyc);
  endtask

  // Monitor: compares DUT outputs to the expectation tagged for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL stale_entry: expectation for cycle %0d not checked, now cycle %0d", e.cyc, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      tests++;
      if (sig_out !== e.sig) begin
        fails++;
        $display("FAIL sig_out cyc=%0d got %b want %0b", cyc, sig_out, e.sig);
      end
      tests++;
      if (busy !== e.busy) begin
        fails++;
        $display("FAIL busy cyc=%0d got %b want %0b", cyc, busy, e.busy);
      end
      tests++;
      if (pending !== PW'(e.pend)) begin
        fails++;
        $display("FAIL pending cyc=%0d got %0d want %0d", cyc, pending, e.pend);
      end
      tests++;
      if (overflow !== e.ovf) begin
        fails++;
        $display("FAIL overflow cyc=%0d got %b want %0b", cyc, overflow, e.ovf);
      end
    end
  end

  logic [63:0] pmask[NSCEN];
  logic [63:0] rmask[NSCEN];

  initial begin
    logic [63:0] pm;
    logic [63:0] rm;
    int dense;
    // Directed scenarios; bit t is the input in cycle t after the scenario's reset cycle 0.
    pmask[0] = 64'h0000_0000_0000_0400;              // single request at 10
    pmask[1] = 64'h0000_0000_0000_1c00;              // queueing 10,11,12
    pmask[2] = 64'h0000_0000_000f_fc00;              // held 10..19: saturation, overflow
    pmask[3] = 64'h0000_0000_0004_0400;              // 10 and 18 (LOW-end request)
    pmask[4] = 64'h0000_0000_0000_0c00;              // 10,11 then reset at 12
    pmask[5] = 64'h0000_0000_0008_0400;              // 10 and 19 (idle re-arm)
    for (int s = 0; s < NSCEN; s++) rmask[s] = 64'h1;
    rmask[4] = 64'h0000_0000_0000_1001;

    // Initial reset held for a few cycles.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);

    for (int s = 0; s < NSCEN; s++) begin
      pm = pmask[s];
      rm = rmask[s];
      for (int t = 0; t < SCEN_LEN; t++) begin
        if (t < 64) drive(pm[t], rm[t]);
        else drive(1'b0, 1'b0);
      end
    end

    // Random traffic alternating between sparse and bursty phases, with rare resets.
    dense = 0;
    for (int i = 0; i < RAND_LEN; i++) begin
      if ($urandom_range(0, 99) == 0) dense = !dense;
      drive((dense != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 399) == 0));
    end

    drive(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
